rotation_slicer: RTL and testbench
==================================

ROTATION_SLICER -- requirements
Module: rotation_slicer

Interface
REQ-001 SHALL have parameter SLICE_LOG, default 6, log2 of angular slices per rotation.
REQ-002 SHALL have parameter CNT_WIDTH, default 20, width of the period counter.
REQ-003 SHALL have parameter MIN_PERIOD, default 256, the shortest accepted rotation period in cycles; legal only if MIN_PERIOD >= 2**SLICE_LOG.
REQ-004 SHALL have port clock, input, 1, the sole clock, shared with the display path.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port rot_pulse, input, 1, debounced rotation index level, already synchronous to clock.
REQ-007 SHALL have port slice_num, output, SLICE_LOG, current angular slice index, which is the frame-select source for the frame reader.
REQ-008 SHALL have port slice_strobe, output, 1, one-cycle pulse marking the start of a slice.
REQ-009 SHALL have port period, output, CNT_WIDTH, the last accepted rotation period in cycles.
REQ-010 SHALL have port locked, output, 1, high while slices are being generated.
REQ-011 SHALL have port stalled, output, 1, high after a rotation timeout.

Function
REQ-012 SHALL detect a rotation edge as rot_pulse high in the current cycle while its registered copy is low, giving one cycle of detection latency.
REQ-013 SHALL use cnt, which is cleared on every accepted edge, increments on all other cycles, and saturates at all-ones; the measured period equals cnt+1 in the edge cycle.
REQ-014 SHALL ignore an edge with cnt+1 < MIN_PERIOD (glitch), leaving all state, outputs, and the cnt count unchanged.
REQ-015 SHALL implement the states UNLOCKED, LOCKING, and LOCKED.
REQ-016 SHALL move from UNLOCKED to LOCKING on any edge, clearing cnt and outputting no strobe.
REQ-017 SHALL, on an accepted edge in LOCKING, load period, move to LOCKED, and set locked=1.
REQ-018 SHALL, on an accepted edge in LOCKED, update period.
REQ-019 SHALL, in LOCKED, use step = period >> SLICE_LOG, taken from the period value of the previous rotation and fixed for the rotation in progress.
REQ-020 SHALL, on an accepted edge that enters or stays in LOCKED, set slice_num=0, clear the slice timer, and assert slice_strobe in the next cycle.
REQ-021 SHALL, in LOCKED when the slice timer reaches step-1, clear the timer, increment slice_num, and pulse slice_strobe.
REQ-022 SHALL saturate slice_num at 2**SLICE_LOG-1, with no wrap and no further strobes until the next edge.
REQ-023 SHALL, when an edge and a timer expiry coincide, let the edge win, giving slice_num=0 and exactly one strobe.
REQ-024 SHALL, when cnt reaches all-ones in LOCKING or LOCKED, move to UNLOCKED, set stalled=1 and locked=0, and hold slice_num while stopping strobes.
REQ-025 SHALL keep stalled high until the next edge, which clears it.
REQ-026 SHALL never assert slice_strobe while locked=0.

Reset
REQ-027 SHALL, on assertion of reset_n, immediately force state=UNLOCKED, cnt=0, the slice timer=0, slice_num=0, slice_strobe=0, period=0, locked=0, stalled=0, and the edge-detect register=0.
REQ-028 SHALL cause the first edge after reset deassertion to follow the UNLOCKED-to-LOCKING rule, so that reset mid-rotation discards the partial measurement.

Structure
REQ-029 SHALL place the state encoding and the default values of SLICE_LOG, CNT_WIDTH, and MIN_PERIOD in the shared package rotation_pkg.
REQ-030 SHALL instantiate exactly one sub-module, slice_timer, which takes step, restart, and enable, and produces the strobe and slice index with saturation; edge detection, period measurement, and the FSM stay in rotation_slicer.

Verification (SLICE_LOG=2, CNT_WIDTH=8, MIN_PERIOD=8)
REQ-031 SHALL cover: edges every 40 cycles -> locked after the 2nd edge, period=40, slice_num 0,1,2,3 with strobes spaced 10 cycles, and slice 0 again at the 3rd edge.
REQ-032 SHALL cover: period change 40->60 -> slices 1..3 at +10/+20/+30, slice_num held at 3 with no strobe until the edge, then period=60 and step 15.
REQ-033 SHALL cover: extra rot_pulse rising 5 cycles after an accepted edge -> ignored, with unchanged cnt, slice_num, and period.
REQ-034 SHALL cover: no edge for 255 cycles after lock -> stalled=1 and locked=0, no strobes, and the next two edges regaining lock with stalled cleared on the first.
REQ-035 SHALL cover: edge coinciding with slice timer expiry -> a single strobe with slice_num=0.
REQ-036 SHALL cover: reset_n pulsed low mid-rotation -> all outputs zero within the same cycle, and lock requiring two fresh edges.

Source files
------------

// File: rtl/rotation_pkg.sv
// Shared definitions for the rotation slicer: state encoding and
// default parameter values.
package rotation_pkg;

  localparam int SLICE_LOG_DEF  = 6;
  localparam int CNT_WIDTH_DEF  = 20;
  localparam int MIN_PERIOD_DEF = 256;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2
  } rot_state_e;

endpackage

// File: rtl/rotation_slicer_slice_timer.sv
// Slice timer: counts step cycles per slice, emits a strobe and the
// slice index, saturating at the last slice.
// Ports: clock, reset_n, step, restart, enable -> strobe, slice_num.
module slice_timer
  import rotation_pkg::*;
#(
  parameter int SLICE_LOG  = SLICE_LOG_DEF,
  parameter int STEP_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic                  restart,
  input  logic                  enable,
  output logic                  strobe,
  output logic [SLICE_LOG-1:0]  slice_num
);

  localparam logic [SLICE_LOG-1:0] LAST = '1;

  logic [STEP_WIDTH-1:0] timer;
  logic                  expire;

  assign expire = timer == (step - STEP_WIDTH'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer     <= '0;
      slice_num <= '0;
      strobe    <= 1'b0;
    end else begin
      strobe <= 1'b0;
      if (restart) begin
        timer     <= '0;
        slice_num <= '0;
        strobe    <= 1'b1;
      end else if (enable) begin
        if (expire) begin
          timer <= '0;
          // Past the last slice: keep timing, stay put, stay quiet.
          if (slice_num != LAST) begin
            slice_num <= slice_num + SLICE_LOG'(1);
            strobe    <= 1'b1;
          end
        end else begin
          timer <= timer + STEP_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/rotation_slicer.sv
// Rotation slicer: measures the rotation period from rot_pulse edges
// and divides each rotation into 2**SLICE_LOG angular slices.
// Ports: clock, reset_n, rot_pulse -> slice_num, slice_strobe,
//        period, locked, stalled.
module rotation_slicer
  import rotation_pkg::*;
#(
  parameter int SLICE_LOG  = SLICE_LOG_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rot_pulse,
  output logic [SLICE_LOG-1:0] slice_num,
  output logic                 slice_strobe,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 locked,
  output logic                 stalled
);

  localparam logic [CNT_WIDTH:0] MIN_P =
    (CNT_WIDTH+1)'(MIN_PERIOD);

  rot_state_e state_q;
  rot_state_e state_d;

  logic                 rot_q;
  logic                 rot_edge;
  logic                 accept;
  logic                 timeout;
  logic                 load_period;
  logic                 restart;
  logic                 set_stall;
  logic                 clr_stall;
  logic                 tmr_en;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] meas;
  logic [CNT_WIDTH-1:0] step;
  logic [CNT_WIDTH:0]   cnt_inc;

  assign rot_edge = rot_pulse & ~rot_q;
  assign cnt_inc  = {1'b0, cnt} + (CNT_WIDTH+1)'(1);
  assign meas     = cnt_inc[CNT_WIDTH] ?
                    '1 : cnt_inc[CNT_WIDTH-1:0];

  // Unlocked accepts any edge; otherwise short gaps are glitches.
  assign accept  = rot_edge &
                   ((state_q == UNLOCKED) | (cnt_inc >= MIN_P));
  assign timeout = (state_q != UNLOCKED) & (&cnt);
  assign locked  = state_q == LOCKED;
  assign tmr_en  = locked & ~timeout;
  assign step    = period >> SLICE_LOG;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= UNLOCKED;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    load_period = 1'b0;
    restart     = 1'b0;
    set_stall   = 1'b0;
    clr_stall   = 1'b0;
    unique case (state_q)
      UNLOCKED: begin
        if (accept) begin
          state_d   = LOCKING;
          clr_stall = 1'b1;
        end
      end
      LOCKING, LOCKED: begin
        if (accept) begin
          state_d     = LOCKED;
          load_period = 1'b1;
          restart     = 1'b1;
        end else if (timeout) begin
          state_d   = UNLOCKED;
          set_stall = 1'b1;
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rot_q   <= 1'b0;
      cnt     <= '0;
      period  <= '0;
      stalled <= 1'b0;
    end else begin
      rot_q <= rot_pulse;
      if (accept)       cnt <= '0;
      else if (!(&cnt)) cnt <= cnt + CNT_WIDTH'(1);
      if (load_period)  period <= meas;
      if (set_stall)      stalled <= 1'b1;
      else if (clr_stall) stalled <= 1'b0;
    end
  end

  slice_timer #(
    .SLICE_LOG  (SLICE_LOG),
    .STEP_WIDTH (CNT_WIDTH)
  ) u_timer (
    .clock     (clock),
    .reset_n   (reset_n),
    .step      (step),
    .restart   (restart),
    .enable    (tmr_en),
    .strobe    (slice_strobe),
    .slice_num (slice_num)
  );

endmodule

// File: tb/tb_rotation_slicer.sv
// Self-checking bench for rotation_slicer (SLICE_LOG=2,
// CNT_WIDTH=8, MIN_PERIOD=8) against a time-since-edge model.
module tb_rotation_slicer;

  localparam int MINP = 8;

  logic       clock;
  logic       reset_n;
  logic       rot_pulse;
  logic [1:0] slice_num;
  logic       slice_strobe;
  logic [7:0] period;
  logic       locked;
  logic       stalled;

  int errors = 0;
  int checks = 0;

  rotation_slicer #(
    .SLICE_LOG  (2),
    .CNT_WIDTH  (8),
    .MIN_PERIOD (MINP)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .rot_pulse    (rot_pulse),
    .slice_num    (slice_num),
    .slice_strobe (slice_strobe),
    .period       (period),
    .locked       (locked),
    .stalled      (stalled)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: 0 unlocked, 1 locking, 2 locked.
  int m_mode, m_age, m_period, m_d, m_slice;
  bit m_prev, m_strobe, m_stall;

  task automatic model_reset();
    m_mode = 0; m_age = 0; m_period = 0; m_d = 0;
    m_slice = 0; m_prev = 0; m_strobe = 0; m_stall = 0;
  endtask

  // Slice index is how many whole steps have elapsed since
  // the last accepted edge, capped at the last slice.
  task automatic model_step(input bit r);
    bit e;
    int meas, st, q;
    e = r && !m_prev;
    m_prev = r;
    meas = m_age + 1;
    if (e && (m_mode == 0 || meas >= MINP)) begin
      m_age = 0;
      if (m_mode == 0) begin
        m_mode = 1; m_stall = 0; m_strobe = 0;
      end else begin
        m_mode = 2;
        m_period = (meas > 255) ? 255 : meas;
        m_d = 0; m_slice = 0; m_strobe = 1;
      end
    end else if (m_mode != 0 && m_age == 255) begin
      m_mode = 0; m_stall = 1; m_strobe = 0;
    end else begin
      if (m_age < 255) m_age++;
      if (m_mode == 2) begin
        m_d++;
        st = m_period >> 2;
        q = m_d / st;
        m_slice = (q > 3) ? 3 : q;
        m_strobe = (m_d % st == 0) && (q <= 3);
      end else begin
        m_strobe = 0;
      end
    end
  endtask

  function automatic logic [12:0] obs();
    return {slice_num, slice_strobe, period, locked, stalled};
  endfunction

  function automatic logic [12:0] expv();
    return {2'(m_slice), m_strobe, 8'(m_period),
            m_mode == 2, m_stall};
  endfunction

  task automatic tick(input bit r);
    @(negedge clock);
    reset_n = 1'b1;
    rot_pulse = r;
    @(posedge clock);
    model_step(r);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (obs() !== 13'd0) begin
      errors++;
      $display("FAIL reset got=%h exp=0", obs());
    end
    checks++;
    if (obs() !== expv()) begin
      errors++;
      $display("FAIL reset_model got=%h exp=%h", obs(), expv());
    end
  endtask

  task automatic test_lock();
    int pers[3] = '{40, 40, 40};
    int w;
    foreach (pers[k]) begin
      w = $urandom_range(1, 4);
      for (int c = 0; c < pers[k]; c++) begin
        tick(c < w);
        checks++;
        if (obs() !== expv()) begin
          errors++;
          $display("FAIL lock k=%0d c=%0d got=%h exp=%h",
                   k, c, obs(), expv());
        end
        if (k == 1 && c == 0) begin
          checks++;
          if ({locked, period} !== {1'b1, 8'd40}) begin
            errors++;
            $display("FAIL lock_period got=%b/%0d exp=1/40",
                     locked, period);
          end
        end
        if (k == 1 && c < 40 && c % 10 == 0) begin
          checks++;
          if ({slice_strobe, slice_num} !== {1'b1, 2'(c / 10)}) begin
            errors++;
            $display("FAIL lock_slice c=%0d got=%b/%0d exp=1/%0d",
                     c, slice_strobe, slice_num, c / 10);
          end
        end
        if (k == 2 && c == 0) begin
          checks++;
          if ({slice_strobe, slice_num} !== 3'b100) begin
            errors++;
            $display("FAIL lock_wrap got=%b/%0d exp=1/0",
                     slice_strobe, slice_num);
          end
        end
      end
    end
  endtask

  task automatic test_period_change();
    int pers[3] = '{40, 60, 40};
    foreach (pers[k]) begin
      for (int c = 0; c < pers[k]; c++) begin
        tick(c < 2);
        checks++;
        if (obs() !== expv()) begin
          errors++;
          $display("FAIL pchg k=%0d c=%0d got=%h exp=%h",
                   k, c, obs(), expv());
        end
        if (k == 1 && c == 45) begin
          checks++;
          if ({slice_strobe, slice_num, period} !==
              {3'b011, 8'd40}) begin
            errors++;
            $display("FAIL pchg_hold got=%b/%0d/%0d exp=0/3/40",
                     slice_strobe, slice_num, period);
          end
        end
        if (k == 2 && c == 15) begin
          checks++;
          if ({slice_strobe, slice_num, period} !==
              {3'b101, 8'd60}) begin
            errors++;
            $display("FAIL pchg_step got=%b/%0d/%0d exp=1/1/60",
                     slice_strobe, slice_num, period);
          end
        end
      end
    end
  endtask

  task automatic test_glitch();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 40; c++) begin
        tick(c < 2 || (k == 0 && c == 5));
        checks++;
        if (obs() !== expv()) begin
          errors++;
          $display("FAIL glitch k=%0d c=%0d got=%h exp=%h",
                   k, c, obs(), expv());
        end
        if (k == 0 && c == 6) begin
          checks++;
          if ({slice_num, period} !== {2'd0, 8'd40}) begin
            errors++;
            $display("FAIL glitch_ign got=%0d/%0d exp=0/40",
                     slice_num, period);
          end
        end
        if (k == 1 && c == 0) begin
          checks++;
          if (period !== 8'd40) begin
            errors++;
            $display("FAIL glitch_cnt got=%0d exp=40", period);
          end
        end
      end
    end
  endtask

  task automatic test_stall();
    int pers[4] = '{300, 40, 40, 40};
    foreach (pers[k]) begin
      for (int c = 0; c < pers[k]; c++) begin
        tick(c < 2);
        checks++;
        if (obs() !== expv()) begin
          errors++;
          $display("FAIL stall k=%0d c=%0d got=%h exp=%h",
                   k, c, obs(), expv());
        end
        checks++;
        if ((slice_strobe & ~locked) !== 1'b0) begin
          errors++;
          $display("FAIL stall_strobe k=%0d c=%0d got=1 exp=0",
                   k, c);
        end
        if (k == 0 && c == 299) begin
          checks++;
          if ({locked, stalled, slice_num} !== 4'b0111) begin
            errors++;
            $display("FAIL stall_flag got=%b%b/%0d exp=01/3",
                     locked, stalled, slice_num);
          end
        end
        if (k == 1 && c == 0) begin
          checks++;
          if ({locked, stalled} !== 2'b00) begin
            errors++;
            $display("FAIL stall_clr got=%b%b exp=00",
                     locked, stalled);
          end
        end
        if (k == 2 && c == 0) begin
          checks++;
          if ({locked, period} !== {1'b1, 8'd40}) begin
            errors++;
            $display("FAIL stall_relock got=%b/%0d exp=1/40",
                     locked, period);
          end
        end
      end
    end
  endtask

  task automatic test_coincide();
    int pers[3] = '{40, 20, 40};
    foreach (pers[k]) begin
      for (int c = 0; c < pers[k]; c++) begin
        tick(c < 2);
        checks++;
        if (obs() !== expv()) begin
          errors++;
          $display("FAIL coin k=%0d c=%0d got=%h exp=%h",
                   k, c, obs(), expv());
        end
        if (k == 2 && c < 2) begin
          checks++;
          if ({slice_strobe, slice_num} !== {c == 0, 2'd0}) begin
            errors++;
            $display("FAIL coin_edge c=%0d got=%b/%0d exp=%0d/0",
                     c, slice_strobe, slice_num, c == 0);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 40; c++) begin
        tick(c < 2);
        checks++;
        if (obs() !== expv()) begin
          errors++;
          $display("FAIL rmid k=%0d c=%0d got=%h exp=%h",
                   k, c, obs(), expv());
        end
        if (k == 0 && c == 17) begin
          #2 reset_n = 1'b0;
          #1;
          model_reset();
          checks++;
          if (obs() !== 13'd0) begin
            errors++;
            $display("FAIL rmid_zero got=%h exp=0", obs());
          end
        end
        if (k > 0 && c == 0) begin
          checks++;
          if (locked !== (k == 2)) begin
            errors++;
            $display("FAIL rmid_lock k=%0d got=%b exp=%0d",
                     k, locked, k == 2);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    int per, w;
    for (int k = 0; k < 40; k++) begin
      per = ($urandom_range(0, 9) == 0) ?
            280 : $urandom_range(5, 70);
      w = $urandom_range(1, 3);
      for (int c = 0; c < per; c++) begin
        tick(c < w);
        checks++;
        if (obs() !== expv()) begin
          errors++;
          $display("FAIL rand k=%0d c=%0d got=%h exp=%h",
                   k, c, obs(), expv());
        end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    rot_pulse = 1'b0;
    model_reset();
    test_reset();
    test_lock();
    test_period_change();
    test_glitch();
    test_stall();
    test_coincide();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
